fp_round_pack: RTL and testbench

- Pipelined rounding and packing stage of the 12-bit two's-complement to 8-bit floating-point converter.
- Sits directly downstream of the leading-bit extraction stage. Consumes sign, leading-zero count, 4-bit significand and fifth (round) bit; produces the packed {S, E[2:0], F[3:0]} word, where value = F * 2^E.
- Two register stages with valid/ready flow control on both sides, plus a saturating count of overflow-clamped results.

---
 rtl/fp_round_pack.sv | 117 +++++++++++
 tb/tb_fp_round_pack.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// Rounding and packing stage of the 12-bit to 8-bit float converter.
// S1 holds the raw exponent and the rounded sum; S2 resolves carry/saturation into {S,E,F}.
module fp_round_pack #(
    parameter int SAT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [3:0]           in_num_leading_zeros,
    input  logic [3:0]           in_significand,
    input  logic                 in_fifth_bit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [2:0]           out_exponent,
    output logic [3:0]           out_significand,
    output logic                 out_saturated,
    output logic [SAT_CNT_W-1:0] sat_count
);

    // Valid/ready: a transfer happens on a rising edge where valid & ready are both 1;
    // the sender holds valid and data stable until that edge.
    logic       s1_valid;
    logic       s1_sign;
    logic       s1_force_sat;
    logic [2:0] s1_exp;
    logic [4:0] s1_sum;

    logic       s1_load;
    logic       s2_load;

    logic       raw_force_sat;
    logic [2:0] raw_exp;
    logic [4:0] raw_sum;

    logic       fin_sat;
    logic [2:0] fin_exp;
    logic [3:0] fin_sig;

    assign s2_load  = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_load;
    assign s1_load  = in_ready;

    always_comb begin
        raw_force_sat = (in_num_leading_zeros == 4'd0);
        raw_exp       = 3'd0;
        raw_sum       = {1'b0, in_significand};
        if (in_num_leading_zeros == 4'd0) begin
            raw_exp = 3'd7;
        end else if (in_num_leading_zeros < 4'd8) begin
            raw_exp = 3'(4'd8 - in_num_leading_zeros);
            raw_sum = {1'b0, in_significand} + {4'b0000, in_fifth_bit};
        end
    end

    // A carry out of the significand renormalises to 1000 and bumps E, unless E is already 7.
    always_comb begin
        fin_sat = 1'b0;
        fin_exp = s1_exp;
        fin_sig = s1_sum[3:0];
        if (s1_force_sat || (s1_sum[4] && s1_exp == 3'd7)) begin
            fin_sat = 1'b1;
            fin_exp = 3'd7;
            fin_sig = 4'b1111;
        end else if (s1_sum[4]) begin
            fin_exp = s1_exp + 3'd1;
            fin_sig = 4'b1000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_force_sat <= 1'b0;
            s1_exp       <= 3'd0;
            s1_sum       <= 5'd0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign      <= in_sign;
                s1_force_sat <= raw_force_sat;
                s1_exp       <= raw_exp;
                s1_sum       <= raw_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_sign        <= 1'b0;
            out_exponent    <= 3'd0;
            out_significand <= 4'd0;
            out_saturated   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign        <= s1_sign;
                out_exponent    <= fin_exp;
                out_significand <= fin_sig;
                out_saturated   <= fin_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_saturated && sat_count != '1) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Randomized bench for fp_round_pack: a value-level reference model feeds an expected
// queue, and one negedge monitor checks handshake, latency, packed fields and sat_count.
module tb_fp_round_pack;

    localparam int SAT_CNT_W = 8;
    localparam int SAT_MAX   = (1 << SAT_CNT_W) - 1;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [3:0]           in_num_leading_zeros;
    logic [3:0]           in_significand;
    logic                 in_fifth_bit;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic [2:0]           out_exponent;
    logic [3:0]           out_significand;
    logic                 out_saturated;
    logic [SAT_CNT_W-1:0] sat_count;

    logic [8:0] exp_q[$];
    int         stamp_q[$];
    int         tests;
    int         failed;
    int         cyc;
    int         model_cnt;
    bit         rand_done;

    fp_round_pack #(.SAT_CNT_W(SAT_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_num_leading_zeros(in_num_leading_zeros),
        .in_significand(in_significand), .in_fifth_bit(in_fifth_bit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exponent(out_exponent),
        .out_significand(out_significand), .out_saturated(out_saturated),
        .sat_count(sat_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value = F * 2^E, rounding the 5th bit into F and renormalising on overflow.
    function automatic logic [8:0] ref_pack(input bit s, input int lz, input int sig, input int fifth);
        int e;
        int f;
        bit sat;
        sat = 0;
        f   = sig;
        if (lz == 0) begin
            e   = 7;
            sat = 1;
        end else if (lz < 8) begin
            e = 8 - lz;
            f = sig + fifth;
        end else begin
            e = 0;
        end
        if (!sat && f == 16) begin
            f = 8;
            e = e + 1;
        end
        if (e > 7) sat = 1;
        if (sat) begin
            e = 7;
            f = 15;
        end
        return {sat, s, e[2:0], f[3:0]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic send(input bit s, input int lz, input int sig, input int f);
        bit acc;
        int n;
        n = 0;
        in_valid             = 1'b1;
        in_sign              = s;
        in_num_leading_zeros = 4'(lz);
        in_significand       = 4'(sig);
        in_fifth_bit         = f[0];
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_rand();
        int lz;
        int sig;
        int f;
        lz  = $urandom_range(0, 12);
        sig = $urandom_range(0, 15);
        f   = 0;
        if (lz <= 8) sig = sig | 8;
        if (lz < 8) f = $urandom_range(0, 1);
        if (lz == 12) sig = 0;
        send(lz == 12 ? 1'b0 : 1'($urandom_range(0, 1)), lz, sig, f);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // scoreboard / compare process
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            stamp_q.delete();
            model_cnt = 0;
        end else begin
            chk("in_ready", in_ready, (exp_q.size() < 2 || out_ready) ? 1 : 0);
            if (exp_q.size() == 0) begin
                chk("idle_valid", out_valid, 0);
            end else if (stamp_q[0] == cyc - 1) begin
                chk("latency_early", out_valid, 0);
            end else begin
                chk("out_valid", out_valid, 1);
                if (out_valid)
                    chk("pack", {out_saturated, out_sign, out_exponent, out_significand}, exp_q[0]);
            end
            chk("sat_count", sat_count, model_cnt);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                if (exp_q[0][8] && model_cnt < SAT_MAX) model_cnt++;
                void'(exp_q.pop_front());
                void'(stamp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_pack(in_sign, in_num_leading_zeros, in_significand, in_fifth_bit));
                stamp_q.push_back(cyc);
            end
        end
    end

    initial begin
        int c0;
        tests = 0; failed = 0; cyc = 0; model_cnt = 0; rand_done = 0;
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_num_leading_zeros = 4'd0;
        in_significand = 4'd0; in_fifth_bit = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fields", {out_saturated, out_sign, out_exponent, out_significand}, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_in_ready", in_ready, 1);

        // hand-computed pins on the model
        chk("pin_round", ref_pack(0, 4, 11, 1), 9'b0_0_100_1100);
        chk("pin_carry", ref_pack(1, 3, 15, 1), 9'b0_1_110_1000);
        chk("pin_small", ref_pack(0, 10, 5, 0), 9'b0_0_000_0101);
        chk("pin_zero", ref_pack(0, 12, 0, 0), 9'b0_0_000_0000);
        chk("pin_sat_carry", ref_pack(0, 1, 15, 1), 9'b1_0_111_1111);
        chk("pin_sat_lz0", ref_pack(0, 0, 15, 1), 9'b1_0_111_1111);
        chk("pin_lz8_nornd", ref_pack(0, 9, 7, 1), 9'b0_0_000_0111);

        // directed vectors
        send(0, 4, 11, 1);
        send(1, 3, 15, 1);
        send(0, 10, 5, 0);
        send(0, 12, 0, 0);
        send(0, 1, 15, 1);
        send(0, 0, 15, 1);
        idle();
        wait_drain();
        @(posedge clk); #1;
        chk("sat_count_two", sat_count, 2);

        // backpressure: out_ready low for cycles 2..5 of a 6-item stream
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'(i & 1), 1 + i, 8 + i, i & 1);
                idle();
            end
            begin
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // full-rate streaming
        c0 = cyc;
        for (int i = 0; i < 20; i++) send_rand();
        chk("full_rate_cycles", cyc - c0, 20);
        idle();
        wait_drain();

        // counter saturation
        for (int i = 0; i < 300; i++) send(1'($urandom_range(0, 1)), 0, 8, 0);
        idle();
        wait_drain();
        @(posedge clk); #1;
        chk("sat_count_hold", sat_count, SAT_MAX);

        // reset with both stages full and output stalled
        out_ready = 1'b0;
        send(0, 2, 9, 1);
        send(1, 5, 12, 0);
        idle();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_fields", {out_saturated, out_sign, out_exponent, out_significand}, 0);
        chk("midrst_sat_count", sat_count, 0);
        chk("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        send(0, 6, 13, 1);
        idle();
        wait_drain();

        // random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    send_rand();
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(posedge clk); #1;
                    end
                end
                idle();
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
